window3x3_stream: RTL

Downstream neighbour of the 2x upsampler: consumes one upsampled single-channel plane per frame as an AXI-Stream raster and produces, for every pixel, the 3x3 zero-padded neighbourhood as one wide AXI-Stream beat. It feeds the 3x3 convolution stage directly. Two line buffers and a 3x3 register window give one window per advance with no frame storage.

---
 rtl/window_pkg.sv | 43 ++++
 rtl/line_buffer.sv | 31 +++
 rtl/window3x3_stream.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 window streamer.
//   - plane size codes and the code-to-width mapping
//   - FSM state encoding
//   - tap indices of the 3x3 window (row-major, tap 0 top-left)
package window_pkg;

    localparam logic [2:0] SZ_8   = 3'd0;
    localparam logic [2:0] SZ_16  = 3'd1;
    localparam logic [2:0] SZ_32  = 3'd2;
    localparam logic [2:0] SZ_64  = 3'd3;
    localparam logic [2:0] SZ_128 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int TAP_NUM = 9;
    localparam int TAP_TL  = 0;
    localparam int TAP_TC  = 1;
    localparam int TAP_TR  = 2;
    localparam int TAP_ML  = 3;
    localparam int TAP_C   = 4;
    localparam int TAP_MR  = 5;
    localparam int TAP_BL  = 6;
    localparam int TAP_BC  = 7;
    localparam int TAP_BR  = 8;

    // Reserved codes fall back to the smallest plane.
    function automatic logic [7:0] w_of(input logic [2:0] code);
        case (code)
            SZ_8:    w_of = 8'd8;
            SZ_16:   w_of = 8'd16;
            SZ_32:   w_of = 8'd32;
            SZ_64:   w_of = 8'd64;
            SZ_128:  w_of = 8'd128;
            default: w_of = 8'd8;
        endcase
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of storage for the window streamer.
//   clk    - clock
//   we     - write enable
//   waddr  - write column
//   wdata  - pixel written
//   raddr  - read column
//   rdata  - combinational read; a same-address write lands at the edge,
//            so the read returns the old value (read-first)
module line_buffer #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/window3x3_stream.sv
// Streams a W x W plane in raster order and emits, per pixel, the
// zero-padded 3x3 neighbourhood as one wide beat.
//   clk, reset      - clock, async active-low reset
//   start, size_sel - frame start pulse and plane size code (latched in IDLE)
//   s_axis_*        - input pixel stream (pixel in low PIX_WIDTH bits)
//   m_axis_*        - window stream; tap i at [i*PIX_WIDTH +: PIX_WIDTH]
//   frame_done      - pulse after the last window is accepted
//   err_tlast       - sticky: input tlast disagreed with the pixel count
//
// state    | meaning
// IDLE     | waiting for start
// RUN      | accepting W*W pixels, one advance per pixel
// FLUSH    | W+1 advances with zero input to push out the last rows
// DRAIN    | holding the final window until it is accepted
module window3x3_stream
    import window_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PIX_WIDTH  = 16,
    parameter int MAX_W      = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             size_sel,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [9*PIX_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   frame_done,
    output logic                   err_tlast
);

    localparam int AW   = $clog2(MAX_W);
    localparam int CNTW = 2 * AW + 1;

    state_t                 state, state_nxt;
    logic [7:0]             w_reg;
    logic [AW-1:0]          w_m1, in_col, rc, cc;
    logic [CNTW-1:0]        adv_cnt, wsq, lag;
    logic                   can_load, accept, adv, emit, start_frame;
    logic                   last_pix, flush_end, rc_last, cc_last;
    logic [PIX_WIDTH-1:0]   pix, lb1_q, lb2_q;
    logic [PIX_WIDTH-1:0]   win      [TAP_NUM];
    logic [PIX_WIDTH-1:0]   win_nxt  [TAP_NUM];
    logic [PIX_WIDTH-1:0]   win_mask [TAP_NUM];
    logic [9*PIX_WIDTH-1:0] out_nxt;
    logic                   unused_tdata;

    assign unused_tdata = ^s_axis_tdata[DATA_WIDTH-1:PIX_WIDTH];

    assign w_m1      = AW'(w_reg - 8'd1);
    assign wsq       = CNTW'(w_reg) * CNTW'(w_reg);
    assign lag       = CNTW'(w_reg) + CNTW'(1);
    assign last_pix  = (adv_cnt == wsq - CNTW'(1));
    assign flush_end = (adv_cnt == wsq + CNTW'(w_reg));
    assign rc_last   = (rc == w_m1);
    assign cc_last   = (cc == w_m1);
    // The centre trails the input by W+1 advances.
    assign emit      = adv && (adv_cnt >= lag);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)                           state_nxt = ST_RUN;
            ST_RUN:   if (accept && last_pix)              state_nxt = ST_FLUSH;
            ST_FLUSH: if (adv && flush_end)                state_nxt = ST_DRAIN;
            ST_DRAIN: if (m_axis_tvalid && m_axis_tready)  state_nxt = ST_IDLE;
            default:                                       state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        can_load      = !m_axis_tvalid || m_axis_tready;
        s_axis_tready = (state == ST_RUN) && can_load;
        accept        = s_axis_tvalid && s_axis_tready;
        adv           = accept || ((state == ST_FLUSH) && can_load);
        start_frame   = (state == ST_IDLE) && start;
        pix           = (state == ST_RUN) ? s_axis_tdata[PIX_WIDTH-1:0] : '0;
    end

    // ---------------- line buffers ----------------
    line_buffer #(.DEPTH(MAX_W), .WIDTH(PIX_WIDTH)) u_lb1 (
        .clk   (clk),
        .we    (adv),
        .waddr (in_col),
        .wdata (pix),
        .raddr (in_col),
        .rdata (lb1_q)
    );

    line_buffer #(.DEPTH(MAX_W), .WIDTH(PIX_WIDTH)) u_lb2 (
        .clk   (clk),
        .we    (adv),
        .waddr (in_col),
        .wdata (lb1_q),
        .raddr (in_col),
        .rdata (lb2_q)
    );

    // ---------------- window shift and padding ----------------
    always_comb begin
        win_nxt[TAP_TL] = win[TAP_TC];
        win_nxt[TAP_TC] = win[TAP_TR];
        win_nxt[TAP_TR] = lb2_q;
        win_nxt[TAP_ML] = win[TAP_C];
        win_nxt[TAP_C]  = win[TAP_MR];
        win_nxt[TAP_MR] = lb1_q;
        win_nxt[TAP_BL] = win[TAP_BC];
        win_nxt[TAP_BC] = win[TAP_BR];
        win_nxt[TAP_BR] = pix;

        // Stale line-buffer data and row/column wrap-around land only on
        // the edges, so masking here keeps frames independent.
        win_mask = win_nxt;
        if (rc == '0) begin
            win_mask[TAP_TL] = '0; win_mask[TAP_TC] = '0; win_mask[TAP_TR] = '0;
        end
        if (rc_last) begin
            win_mask[TAP_BL] = '0; win_mask[TAP_BC] = '0; win_mask[TAP_BR] = '0;
        end
        if (cc == '0) begin
            win_mask[TAP_TL] = '0; win_mask[TAP_ML] = '0; win_mask[TAP_BL] = '0;
        end
        if (cc_last) begin
            win_mask[TAP_TR] = '0; win_mask[TAP_MR] = '0; win_mask[TAP_BR] = '0;
        end

        out_nxt = '0;
        for (int i = 0; i < TAP_NUM; i++) begin
            out_nxt[i*PIX_WIDTH +: PIX_WIDTH] = win_mask[i];
        end
    end

    // ---------------- counters, window, output register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_reg         <= 8'd8;
            adv_cnt       <= '0;
            in_col        <= '0;
            rc            <= '0;
            cc            <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
            err_tlast     <= 1'b0;
            for (int i = 0; i < TAP_NUM; i++) win[i] <= '0;
        end else begin
            frame_done <= (state == ST_DRAIN) && m_axis_tvalid && m_axis_tready;

            if (start_frame) begin
                w_reg     <= w_of(size_sel);
                adv_cnt   <= '0;
                in_col    <= '0;
                rc        <= '0;
                cc        <= '0;
                err_tlast <= 1'b0;
            end else if (accept && (s_axis_tlast != last_pix)) begin
                err_tlast <= 1'b1;
            end

            if (adv) begin
                adv_cnt <= adv_cnt + CNTW'(1);
                in_col  <= (in_col == w_m1) ? '0 : in_col + AW'(1);
                for (int i = 0; i < TAP_NUM; i++) win[i] <= win_nxt[i];
            end

            if (emit) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= out_nxt;
                m_axis_tlast  <= rc_last && cc_last;
                if (cc_last) begin
                    cc <= '0;
                    rc <= rc + AW'(1);
                end else begin
                    cc <= cc + AW'(1);
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
